// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the execute-stage control and seq_alu.
// The control side drives the request and the ALU drives the result and flags.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Func;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             C;
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output start, A, B, Func,
    input  busy, done, out, C, Z, N, V
  );

  modport slave (
    input  start, A, B, Func,
    output busy, done, out, C, Z, N, V
  );
endinterface

// File: rtl/seq_alu.sv
// Clocked ALU with registered result and flags.
// Single-cycle ops finish on the accepting edge; mul iterates WIDTH steps.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SH = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;
  localparam int M  = WIDTH - 1;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic [M:0]      out_q, out_d;
  logic [3:0]      flg_q, flg_d;
  logic [W2-1:0]   mcand_q, mcand_d;
  logic [M:0]      mplier_q, mplier_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [SH-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]  ext;
  logic [M:0]      res;
  logic            op_c;
  logic            op_v;
  logic [SH-1:0]   amt;
  logic [W2-1:0]   mul_acc;

  // Single-cycle result and C/V from the live operands.
  always_comb begin
    ext  = '0;
    res  = '0;
    op_c = 1'b0;
    op_v = 1'b0;
    amt  = bus.B[SH-1:0];
    unique case (bus.Func)
      3'b000: begin
        ext  = {1'b0, bus.A} + {1'b0, bus.B};
        res  = ext[M:0];
        op_c = ext[WIDTH];
        op_v = ~(bus.A[M] ^ bus.B[M]) & (bus.A[M] ^ ext[M]);
      end
      3'b001: begin
        ext  = {1'b0, bus.A} - {1'b0, bus.B};
        res  = ext[M:0];
        op_c = ext[WIDTH];
        op_v = (bus.A[M] ^ bus.B[M]) & (bus.A[M] ^ ext[M]);
      end
      3'b010: res = bus.A & bus.B;
      3'b011: res = bus.A | bus.B;
      3'b100: res = bus.A ^ bus.B;
      3'b101: begin
        // Bit WIDTH catches the last bit pushed out the top.
        ext  = {1'b0, bus.A} << amt;
        res  = ext[M:0];
        op_c = ext[WIDTH];
      end
      3'b110: begin
        // Bit 0 catches the last bit pushed out the bottom.
        ext  = {bus.A, 1'b0} >> amt;
        res  = ext[WIDTH:1];
        op_c = ext[0];
      end
      default: ;
    endcase
  end

  // One shift-add step: add the multiplicand when the low multiplier bit is set.
  always_comb begin
    mul_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state, datapath and result/flag update.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    out_d    = out_q;
    flg_d    = flg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.Func == 3'b111) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            out_d  = res;
            flg_d  = {op_c, res == '0, res[M], op_v};
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = mul_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH'(1);
        if (cnt_q == SH'(WIDTH - 1)) begin
          out_d   = mul_acc[M:0];
          flg_d   = {|mul_acc[W2-1:WIDTH],
                     mul_acc[M:0] == '0,
                     mul_acc[M],
                     |mul_acc[W2-1:WIDTH]};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      out_q    <= '0;
      flg_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      out_q    <= out_d;
      flg_q    <= flg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy = (state_q == MUL);
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.C    = flg_q[3];
  assign bus.Z    = flg_q[2];
  assign bus.N    = flg_q[1];
  assign bus.V    = flg_q[0];
endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu at WIDTH=32 and WIDTH=8.
// Expected values come from a plain-arithmetic reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) i32 ();
  seq_alu_if #(.WIDTH(8))  i8 ();

  seq_alu #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
  seq_alu #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [63:0] out;
    logic [3:0]  f;
  } res_t;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t model(input int w, input bit [2:0] f,
                                 input logic [63:0] ai,
                                 input logic [63:0] bi);
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] o;
    logic [63:0] p;
    longint sa, sb, r, lo, hi;
    bit c, v;
    int amt;
    res_t rr;
    m  = (64'd1 << w) - 64'd1;
    a  = ai & m;
    b  = bi & m;
    o  = '0;
    c  = 0;
    v  = 0;
    sa = longint'(a);
    sb = longint'(b);
    if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
    if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    amt = int'(b % 64'(w));
    case (f)
      3'd0: begin
        p = a + b; o = p & m; c = ((p >> w) & 64'd1) != 0;
        r = sa + sb; v = (r > hi) || (r < lo);
      end
      3'd1: begin
        o = (a - b) & m; c = (a < b);
        r = sa - sb; v = (r > hi) || (r < lo);
      end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: begin
        o = (a << amt) & m;
        c = (amt != 0) && (((a >> (w - amt)) & 64'd1) != 0);
      end
      3'd6: begin
        o = a >> amt;
        c = (amt != 0) && (((a >> (amt - 1)) & 64'd1) != 0);
      end
      default: begin
        p = a * b; o = p & m; c = (p >> w) != 0; v = c;
      end
    endcase
    rr.out = o;
    rr.f   = {c, o == 0, ((o >> (w - 1)) & 64'd1) != 0, v};
    return rr;
  endfunction

  function automatic logic [63:0] d_out(input int w);
    return (w == 32) ? 64'(i32.out) : 64'(i8.out);
  endfunction

  function automatic logic [3:0] d_flg(input int w);
    return (w == 32) ? {i32.C, i32.Z, i32.N, i32.V}
                     : {i8.C, i8.Z, i8.N, i8.V};
  endfunction

  function automatic logic d_done(input int w);
    return (w == 32) ? i32.done : i8.done;
  endfunction

  function automatic logic d_busy(input int w);
    return (w == 32) ? i32.busy : i8.busy;
  endfunction

  task automatic drive(input int w, input bit s, input bit [2:0] f,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      i32.start = s; i32.Func = f; i32.A = a[31:0]; i32.B = b[31:0];
    end else begin
      i8.start = s; i8.Func = f; i8.A = a[7:0]; i8.B = b[7:0];
    end
  endtask

  task automatic set_start(input int w, input bit s);
    if (w == 32) i32.start = s;
    else i8.start = s;
  endtask

  task automatic run(input string tag, input int w, input bit [2:0] f,
                     input logic [63:0] a, input logic [63:0] b,
                     input int poke = -1, input int rst_at = -1);
    res_t e;
    int lat;
    int nd;
    bit bz_ok;
    e     = model(w, f, a, b);
    lat   = 0;
    bz_ok = 1;
    @(negedge clk);
    drive(w, 1, f, a, b);
    @(negedge clk);
    set_start(w, 0);
    if (f == 3'b111) begin
      chk({tag, "_busy_start"}, 64'(d_busy(w)), 64'd1);
      while (!d_done(w) && lat < 2 * w) begin
        if (lat == poke - 1) drive(w, 1, 3'b000, 64'd1, 64'd1);
        if (lat == rst_at - 1) begin
          @(posedge clk);
          #2 rst_n = 1'b0;
          #1;
          chk({tag, "_rst_busy"}, 64'(d_busy(w)), 64'd0);
          chk({tag, "_rst_out"}, d_out(w), 64'd0);
          chk({tag, "_rst_flg"}, 64'(d_flg(w)), 64'd0);
          chk({tag, "_rst_done"}, 64'(d_done(w)), 64'd0);
          @(negedge clk);
          rst_n = 1'b1;
          nd = 0;
          repeat (2 * w + 4) begin
            @(negedge clk);
            if (d_done(w)) nd++;
          end
          chk({tag, "_no_done"}, 64'(nd), 64'd0);
          return;
        end
        @(negedge clk);
        lat++;
        set_start(w, 0);
        if (!d_done(w) && !d_busy(w)) bz_ok = 0;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(w));
      chk({tag, "_busy_hold"}, 64'(bz_ok), 64'd1);
    end
    chk({tag, "_done"}, 64'(d_done(w)), 64'd1);
    chk({tag, "_busy"}, 64'(d_busy(w)), 64'd0);
    chk({tag, "_out"}, d_out(w), e.out);
    chk({tag, "_flg"}, 64'(d_flg(w)), 64'(e.f));
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(d_done(w)), 64'd0);
    chk({tag, "_out_hold"}, d_out(w), e.out);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'($urandom_range(0, 40));
      default: return {32'd0, $urandom} & m;
    endcase
  endfunction

  res_t e1;
  res_t e2;

  initial begin
    rst_n = 1'b0;
    drive(32, 0, 3'd0, 64'd0, 64'd0);
    drive(8, 0, 3'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    chk("rst32_out", d_out(32), 64'd0);
    chk("rst32_flg", 64'(d_flg(32)), 64'd0);
    chk("rst32_busy", 64'(d_busy(32)), 64'd0);
    chk("rst32_done", 64'(d_done(32)), 64'd0);
    chk("rst8_out", d_out(8), 64'd0);
    chk("rst8_flg", 64'(d_flg(8)), 64'd0);
    rst_n = 1'b1;

    run("add_wrap", 32, 3'd0, 64'hFFFF_FFFF, 64'h1);

    e1 = model(32, 3'd1, 64'h8000_0000, 64'h1);
    e2 = model(32, 3'd1, 64'h5, 64'h7);
    @(negedge clk);
    drive(32, 1, 3'd1, 64'h8000_0000, 64'h1);
    @(negedge clk);
    drive(32, 1, 3'd1, 64'h5, 64'h7);
    chk("b2b1_done", 64'(d_done(32)), 64'd1);
    chk("b2b1_out", d_out(32), e1.out);
    chk("b2b1_flg", 64'(d_flg(32)), 64'(e1.f));
    @(negedge clk);
    set_start(32, 0);
    chk("b2b2_done", 64'(d_done(32)), 64'd1);
    chk("b2b2_out", d_out(32), e2.out);
    chk("b2b2_flg", 64'(d_flg(32)), 64'(e2.f));

    run("lsl", 32, 3'd5, 64'h8000_0001, 64'h21);
    run("lsr0", 32, 3'd6, 64'h1, 64'h0);
    run("mul_poke", 32, 3'd7, 64'h0001_0000, 64'h0001_0000, 5);
    run("mul_ffff", 32, 3'd7, 64'h0000_FFFF, 64'h3);
    run("mul_rst", 32, 3'd7, 64'h1234_5678, 64'h9ABC_DEF1, -1, 10);
    run("mul8", 8, 3'd7, 64'h0F, 64'h11);
    run("xor8", 8, 3'd4, 64'hAA, 64'hAA);

    for (int i = 0; i < 160; i++) begin
      int w;
      bit [2:0] f;
      w = ($urandom_range(0, 1) == 0) ? 32 : 8;
      f = 3'($urandom_range(0, 7));
      run("rnd", w, f, pick(w), pick(w));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
